// File: rtl/packetfilt_fwd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : packetfilt_fwd_arbiter
// Purpose  : Packet-granular round-robin arbiter. It merges N_SRC filter-core
//            forwarder streams onto one registered AXI Stream output. The
//            arbiter locks onto the granted source from its first beat until
//            its TLAST beat, then re-arbitrates.
// Ports    : axi_aclk / axi_areset   clock, asynchronous active-high reset
//            src_TDATA/TVALID/TLAST  packed per-source input streams
//            src_TREADY              per-source ready (one-hot or zero)
//            fwd_TDATA/TVALID/TLAST  registered merged output stream
//            fwd_TREADY              downstream ready
//            busy                    high while a source is locked
//            grant_id                current or most recent grantee
//            pkt_count               packets forwarded (optional, see below)
// Options  : define PACKETFILT_FWD_ARB_PKT_COUNT_EN to add the 32-bit
//            wrapping pkt_count output.
// Revision : 1.0 - initial release
// ============================================================================
module packetfilt_fwd_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 128,
    localparam int GW        = $clog2(N_SRC)
) (
    input  logic                        axi_aclk,
    input  logic                        axi_areset,
    input  logic [N_SRC*DATA_WIDTH-1:0] src_TDATA,
    input  logic [N_SRC-1:0]            src_TVALID,
    input  logic [N_SRC-1:0]            src_TLAST,
    output logic [N_SRC-1:0]            src_TREADY,
    output logic [DATA_WIDTH-1:0]       fwd_TDATA,
    output logic                        fwd_TVALID,
    output logic                        fwd_TLAST,
    input  logic                        fwd_TREADY,
    output logic                        busy,
`ifdef PACKETFILT_FWD_ARB_PKT_COUNT_EN
    output logic [31:0]                 pkt_count,
`endif
    output logic [GW-1:0]               grant_id
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam logic [N_SRC-1:0] c_ONE = {{(N_SRC-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           last_grant_q;
    logic                    fwd_valid_q;
    logic                    fwd_last_q;
    logic [DATA_WIDTH-1:0]   fwd_data_q;

    logic                    w_pick_found;
    logic [GW-1:0]           w_pick_idx;
    logic                    w_out_ready;
    logic                    w_take;
    logic                    w_beat_last;
    logic [DATA_WIDTH-1:0]   w_beat_data;

    // Round-robin search: first valid source strictly after the last
    // completed grantee, wrapping modulo N_SRC.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int off = 1; off <= N_SRC; off++) begin
            int            sum;
            logic [GW-1:0] cand;
            sum  = int'(last_grant_q) + off;
            if (sum >= N_SRC) begin
                sum = sum - N_SRC;
            end
            cand = GW'(sum);
            if (!w_pick_found && src_TVALID[cand]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = cand;
            end
        end
    end

    // The output register can accept a beat when empty or draining this
    // cycle; this is the combinational fwd_TREADY -> src_TREADY path.
    assign w_out_ready = !fwd_valid_q || fwd_TREADY;
    assign src_TREADY  = (state_q == S_LOCKED && w_out_ready) ? (c_ONE << grant_q) : '0;
    assign w_take      = (state_q == S_LOCKED) && w_out_ready && src_TVALID[grant_q];
    assign w_beat_last = src_TLAST[grant_q];
    assign w_beat_data = src_TDATA[grant_q*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_SRC - 1);
            fwd_valid_q  <= 1'b0;
            fwd_last_q   <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pick_found) begin
                        grant_q <= w_pick_idx;
                        state_q <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    // The lock is released only by the grantee's TLAST beat;
                    // a grantee that stalls mid-packet keeps the lock.
                    if (w_take && w_beat_last) begin
                        last_grant_q <= grant_q;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (w_take) begin
                fwd_valid_q <= 1'b1;
                fwd_data_q  <= w_beat_data;
                fwd_last_q  <= w_beat_last;
            end else if (fwd_valid_q && fwd_TREADY) begin
                fwd_valid_q <= 1'b0;
            end
        end
    end

    assign fwd_TDATA  = fwd_data_q;
    assign fwd_TVALID = fwd_valid_q;
    assign fwd_TLAST  = fwd_last_q;
    assign busy       = (state_q == S_LOCKED);
    assign grant_id   = grant_q;

`ifdef PACKETFILT_FWD_ARB_PKT_COUNT_EN
    logic [31:0] pkt_count_q;
    logic [31:0] pkt_count_d;

    // Natural 32-bit overflow provides the wrap to zero.
    assign pkt_count_d = pkt_count_q + 32'd1;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            pkt_count_q <= '0;
        end else if (fwd_valid_q && fwd_TREADY && fwd_last_q) begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packetfilt_fwd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_packetfilt_fwd_arbiter
// Purpose  : Self-checking bench for packetfilt_fwd_arbiter. Source packets
//            are queued per source; a transaction-level round-robin model
//            derives the expected packet service order, and every source and
//            output handshake is scored against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packetfilt_fwd_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] src_TDATA;
    logic [N-1:0]    src_TVALID;
    logic [N-1:0]    src_TLAST;
    logic [N-1:0]    src_TREADY;
    logic [DW-1:0]   fwd_TDATA;
    logic            fwd_TVALID;
    logic            fwd_TLAST;
    logic            fwd_TREADY;
    logic            busy;
    logic [GW-1:0]   grant_id;
`ifdef PACKETFILT_FWD_ARB_PKT_COUNT_EN
    logic [31:0]     pkt_count;
`endif

    always #5 clk = ~clk;

    packetfilt_fwd_arbiter #(.N_SRC(N), .DATA_WIDTH(DW)) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .src_TDATA  (src_TDATA),
        .src_TVALID (src_TVALID),
        .src_TLAST  (src_TLAST),
        .src_TREADY (src_TREADY),
        .fwd_TDATA  (fwd_TDATA),
        .fwd_TVALID (fwd_TVALID),
        .fwd_TLAST  (fwd_TLAST),
        .fwd_TREADY (fwd_TREADY),
        .busy       (busy),
`ifdef PACKETFILT_FWD_ARB_PKT_COUNT_EN
        .pkt_count  (pkt_count),
`endif
        .grant_id   (grant_id)
    );

    typedef struct packed {
        logic [3:0]    src;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DW:0]   src_q [N][$];     // {last, data} per source
    beat_t         exp_src[$];
    beat_t         exp_fwd[$];
    int            model_last = N - 1;
    int            gap_pct = 0;
    int            stall_pct = 0;
    int            cyc = 0;
    int            last_src_hs_cyc = -1;
    int            first_fwd_cyc = -1;
    int            n_lasts = 0;
    logic [N-1:0]  hs_src = '0;
    logic [N-1:0]  mid = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        for (int b = 0; b < len; b++) begin
            logic [DW-1:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            src_q[s].push_back({(b == len - 1), d});
        end
    endtask

    // Expected service order: repeatedly serve the next non-empty source
    // after the previously served one, one whole packet at a time.
    task automatic plan();
        logic [DW:0] tmp [N][$];
        for (int i = 0; i < N; i++) tmp[i] = src_q[i];
        forever begin
            int pick;
            pick = -1;
            for (int off = 1; off <= N; off++) begin
                int s;
                s = (model_last + off) % N;
                if (pick < 0 && tmp[s].size() > 0) pick = s;
            end
            if (pick < 0) break;
            forever begin
                logic [DW:0] b;
                beat_t       e;
                b = tmp[pick].pop_front();
                e.src  = 4'(pick);
                e.last = b[DW];
                e.data = b[DW-1:0];
                exp_src.push_back(e);
                exp_fwd.push_back(e);
                if (b[DW]) break;
            end
            model_last = pick;
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_fwd.size() > 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic cycle();
        logic [DW:0] b;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs_src[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                mid[i] = !b[DW];
            end
        end
        fwd_TREADY = ($urandom_range(99) >= stall_pct);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                src_TVALID[i] = !(mid[i] && ($urandom_range(99) < gap_pct));
                src_TLAST[i]  = b[DW];
                src_TDATA[i*DW +: DW] = b[DW-1:0];
            end else begin
                src_TVALID[i] = 1'b0;
                src_TLAST[i]  = 1'b0;
                src_TDATA[i*DW +: DW] = '0;
            end
        end
        #1;
        check("ready_onehot0", ($countones(src_TREADY) <= 1), 1);
        if (fwd_TVALID && !fwd_TREADY) check("ready_in_stall", src_TREADY, 0);
        hs_src = src_TVALID & src_TREADY;
        for (int i = 0; i < N; i++) begin
            if (hs_src[i]) begin
                if (exp_src.size() == 0) begin
                    check("src_unexpected", hs_src[i], 0);
                end else begin
                    beat_t e;
                    e = exp_src.pop_front();
                    check("src_order", i, e.src);
                    check("src_grant_id", grant_id, i);
                    check("src_busy", busy, 1);
                    last_src_hs_cyc = cyc;
                end
            end
        end
        if (fwd_TVALID && first_fwd_cyc < 0) first_fwd_cyc = cyc;
        if (fwd_TVALID && fwd_TREADY) begin
            if (exp_fwd.size() == 0) begin
                check("fwd_unexpected", fwd_TVALID, 0);
            end else begin
                beat_t e;
                e = exp_fwd.pop_front();
                check("fwd_data", fwd_TDATA, e.data);
                check("fwd_last", fwd_TLAST, e.last);
                if (fwd_TLAST) n_lasts++;
            end
        end
    endtask

    task automatic run_until_done(input int budget);
        int k;
        k = 0;
        while (pending() && k < budget) begin
            cycle();
            k++;
        end
        if (pending()) check("timeout_pending", exp_fwd.size(), 0);
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_src.delete();
        exp_fwd.delete();
        hs_src     = '0;
        mid        = '0;
        model_last = N - 1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        src_TVALID = '0;
        flush();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int k;
        src_TDATA  = '0;
        src_TVALID = '0;
        src_TLAST  = '0;
        fwd_TREADY = 1'b1;
        #1;
        check("rst_fwd_valid", fwd_TVALID, 0);
        check("rst_fwd_last", fwd_TLAST, 0);
        check("rst_fwd_data", fwd_TDATA, 0);
        check("rst_src_ready", src_TREADY, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single source, 3-beat packet: latency and post-packet state.
        add_pkt(1, 3);
        plan();
        first_fwd_cyc = -1;
        start = cyc + 1;
        run_until_done(50);
        check("lat_first_fwd", first_fwd_cyc, start + 2);
        check("single_busy_after", busy, 0);
        check("single_grant_id", grant_id, 1);

        // Contention from reset: order 0,1,2,3,0 with one idle cycle per packet.
        reset_pulse();
        add_pkt(0, 2); add_pkt(0, 2);
        add_pkt(1, 2); add_pkt(2, 2); add_pkt(3, 2);
        plan();
        start = cyc + 1;
        run_until_done(100);
        check("contention_last_src_cyc", last_src_hs_cyc, start + 14);

        // Randomized traffic with source gaps (lock hold) and output stalls.
        gap_pct   = 35;
        stall_pct = 35;
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < N; s++) begin
                int np;
                np = $urandom_range(3);
                for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 6));
            end
            plan();
            run_until_done(3000);
        end

        // Reset after 2 of 4 beats: async clear, partial packet dropped.
        gap_pct   = 0;
        stall_pct = 0;
        add_pkt(3, 4);
        plan();
        k = 0;
        for (int n = 0; n < 20 && k < 2; n++) begin
            cycle();
            if (hs_src[3]) k++;
        end
        check("midpkt_beats_taken", k, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_fwd_valid", fwd_TVALID, 0);
        check("midrst_fwd_last", fwd_TLAST, 0);
        check("midrst_grant_id", grant_id, 0);
        check("midrst_src_ready", src_TREADY, 0);
        src_TVALID = '0;
        flush();
        @(negedge clk);
        rst = 1'b0;
        n_lasts = 0;
        add_pkt(3, 2);
        add_pkt(2, 2);
        plan();
        run_until_done(100);
        check("after_rst_grant_id", grant_id, 3);

`ifdef PACKETFILT_FWD_ARB_PKT_COUNT_EN
        for (int p = 0; p < 5; p++) add_pkt(p % N, 1 + p);
        plan();
        run_until_done(200);
        check("pkt_count_7", pkt_count, n_lasts);
        check("pkt_count_7_abs", pkt_count, 7);
        @(negedge clk);
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_q;
        add_pkt(1, 2);
        plan();
        run_until_done(50);
        check("pkt_count_wrap", pkt_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/packetfilt_fwd_arbiter.md
# packetfilt_fwd_arbiter

Packet-granular round-robin arbiter that shares a single forwarder AXI Stream output between N_SRC packet filter cores. Each core presents its accepted packets on its own stream; the arbiter locks onto one source for the whole packet (through TLAST), then re-arbitrates. It sits between the filter cores' forwarder outputs and the design-level fwd_T* port, and has a registered output stage.

## Interface
- N_SRC, 4: number of filter cores; legal range 2..16.
- DATA_WIDTH, 128: stream data width in bits; equals the filter cores' packet data width.
- axi_aclk  in  1  sole clock; all logic on rising edge.
- axi_areset  in  1  asynchronous, active-high reset.
- src_TDATA  in  N_SRC*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_TVALID  in  N_SRC  per-source valid.
- src_TLAST  in  N_SRC  per-source last beat of packet.
- src_TREADY  out  N_SRC  per-source ready; at most one bit high in any cycle.
- fwd_TDATA  out  DATA_WIDTH  registered output data.
- fwd_TVALID  out  1  registered output valid.
- fwd_TLAST  out  1  registered output last.
- fwd_TREADY  in  1  downstream ready.
- busy  out  1  high while in LOCKED.
- grant_id  out  $clog2(N_SRC)  index of the current or most recent grantee.

## Operation
- States: IDLE and LOCKED; reset state is IDLE.
- IDLE: request vector = src_TVALID. If any bit is set, pick the first set bit searching upward, with wrap, from (last_grant+1) mod N_SRC. Register that index into grant_id and go to LOCKED. No beat moves in IDLE.
- LOCKED: src_TREADY[grant_id] = !fwd_TVALID | fwd_TREADY. All other src_TREADY bits are 0.
- Beat transfer: a source beat is taken when src_TVALID[g] & src_TREADY[g]. The taken beat loads the output register (fwd_TVALID=1, with DATA and LAST).
- Output register: clears fwd_TVALID on fwd_TVALID & fwd_TREADY when no new beat loads in the same cycle. It holds DATA, LAST and VALID stable while fwd_TREADY=0.
- Packet end: a taken beat with src_TLAST[g]=1 sets last_grant=g and returns to IDLE on the next edge.
- Lock persistence: if the grantee drops TVALID mid-packet, the lock holds indefinitely. No other source is served until its TLAST.
- Reset values: fwd_TVALID=0, fwd_TLAST=0, fwd_TDATA=0, src_TREADY=0, busy=0, grant_id=0, last_grant=N_SRC-1, so source 0 has first priority.
- Reset mid-packet: the partial packet is dropped, with no TLAST emitted downstream. Arbitration restarts from source 0.

## Timing
- Arbitration latency: source TVALID rises at cycle 0 in IDLE → grant registered at edge 1 → src_TREADY high in cycle 1 → first beat on fwd_TVALID in cycle 2.
- Throughput inside a packet: 1 beat per cycle while fwd_TREADY=1.
- Packet gap: exactly one idle cycle on the source side between consecutive packets (the IDLE arbitration cycle), even when the same source has back-to-back packets.
- Single-beat packet: LOCKED for one transfer cycle only.
- Fairness: no source waits for more than N_SRC-1 other packets once its TVALID is high.
- fwd_TREADY low: src_TREADY goes low in the same cycle if fwd_TVALID=1 (combinational path from fwd_TREADY to src_TREADY).

## Configuration
- Macro: PACKETFILT_FWD_ARB_PKT_COUNT_EN.
- Defined: adds output port pkt_count [31:0], reset to 0. It increments by 1 on each fwd_TVALID & fwd_TREADY & fwd_TLAST and wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Single source: src1 sends a 3-beat packet (A,B,C; TLAST on C), fwd_TREADY=1 → fwd shows A,B,C in cycles 2..4, TLAST only on C, grant_id=1, busy falls after C.
- Contention: all 4 sources hold 2-beat packets from reset → service order 0,1,2,3,0 with one idle source cycle between packets.
- Backpressure: fwd_TREADY low for 5 cycles mid-packet → fwd_TDATA/TLAST held stable, src_TREADY[g]=0, no beat lost or duplicated; compare against a scoreboard.
- Lock hold: grantee drops TVALID for 10 cycles mid-packet while src2 is valid → src_TREADY[2] stays 0 and the packet completes before src2 is granted.
- Reset mid-packet: assert axi_areset after 2 of 4 beats → fwd_TVALID=0, fwd_TLAST=0, grant_id=0 immediately (asynchronous); the next grant goes to the lowest valid index.
- With PACKETFILT_FWD_ARB_PKT_COUNT_EN: forward 7 packets → pkt_count=7. Preload near 0xFFFFFFFF via force → wraps to 0.
